// File: rtl/reg4_sequencer.sv
// Two-requester round-robin sequencer that drives one operation at a time into an
// external 4-bit register and reports the register contents once the operation lands.
module reg4_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [1:0] op0,
  input  logic [3:0] dat0,
  input  logic       req1,
  input  logic [1:0] op1,
  input  logic [3:0] dat1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [1:0] reg_s,
  output logic [3:0] reg_d,
  input  logic [3:0] reg_q,
  output logic       done,
  output logic       done_id,
  output logic [3:0] result,
  output logic       busy
);

  typedef enum logic [1:0] {INIT, IDLE, ISSUE, CAPTURE} state_e;

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [1:0] op_q, op_d;
  logic [3:0] dat_q, dat_d;
  logic       id_q, id_d;
  logic       done_q;
  logic       doneId_q;
  logic [3:0] result_q;
  logic       anyReq;
  logic       pick;

  // With both requesting the pointer decides; otherwise the lone requester wins.
  assign anyReq = req0 | req1;
  assign pick   = (req0 && req1) ? ptr_q : req1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    dat_d   = dat_q;
    id_d    = id_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    reg_s   = 2'b00;
    reg_d   = 4'b0000;
    case (state_q)
      INIT: begin
        reg_s   = 2'b01;
        state_d = IDLE;
      end
      IDLE: begin
        if (anyReq) begin
          gnt0    = ~pick;
          gnt1    = pick;
          id_d    = pick;
          op_d    = pick ? op1 : op0;
          dat_d   = pick ? dat1 : dat0;
          ptr_d   = ~pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        reg_s   = op_q;
        reg_d   = (op_q == 2'b11) ? dat_q : 4'b0000;
        state_d = CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // Result is sampled at the closing edge of CAPTURE, one cycle after the register acted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      ptr_q    <= 1'b0;
      op_q     <= 2'b00;
      dat_q    <= 4'b0000;
      id_q     <= 1'b0;
      done_q   <= 1'b0;
      doneId_q <= 1'b0;
      result_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      dat_q   <= dat_d;
      id_q    <= id_d;
      done_q  <= (state_q == CAPTURE);
      if (state_q == CAPTURE) begin
        result_q <= reg_q;
        doneId_q <= id_q;
      end
    end
  end

  assign done    = done_q;
  assign done_id = doneId_q;
  assign result  = result_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_reg4_sequencer.sv
// Directed bench for reg4_sequencer; models the controlled 4-bit register and checks
// each step against hand-computed values.
module tb_reg4_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [1:0] op0, op1;
   logic [3:0] dat0, dat1;
   logic       gnt0, gnt1;
   logic [1:0] reg_s;
   logic [3:0] reg_d;
   logic [3:0] reg_q;
   logic       done, done_id, busy;
   logic [3:0] result;

   int vectors = 0;
   int miscompares = 0;

   reg4_sequencer dut (
      .clk(clk), .rst(rst),
      .req0(req0), .op0(op0), .dat0(dat0),
      .req1(req1), .op1(op1), .dat1(dat1),
      .gnt0(gnt0), .gnt1(gnt1),
      .reg_s(reg_s), .reg_d(reg_d), .reg_q(reg_q),
      .done(done), .done_id(done_id), .result(result), .busy(busy)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Behavioural model of the controlled register: hold, clear, invert, load.
   always_ff @(posedge clk) begin
      case (reg_s)
         2'b01:   reg_q <= 4'b0000;
         2'b10:   reg_q <= ~reg_q;
         2'b11:   reg_q <= reg_d;
         default: reg_q <= reg_q;
      endcase
   end

   // Drives both requester interfaces at once.
   task automatic applyStimulus(input logic r0, input logic [1:0] o0, input logic [3:0] d0,
                                input logic r1, input logic [1:0] o1, input logic [3:0] d1);
      req0 = r0; op0 = o0; dat0 = d0;
      req1 = r1; op1 = o1; dat1 = d1;
   endtask

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   // Linear directed sequence; inputs change and outputs are sampled around the falling edge.
   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
      repeat (2) @(negedge clk);
      checkOutput("rst_reg_s", 4'(reg_s), 4'b0001);
      checkOutput("rst_reg_d", reg_d, 4'b0000);
      checkOutput("rst_busy", 4'(busy), 4'd1);
      checkOutput("rst_gnt", {2'b00, gnt1, gnt0}, 4'b0000);
      checkOutput("rst_done", 4'(done), 4'd0);
      checkOutput("rst_result", result, 4'b0000);

      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("init_reg_s", 4'(reg_s), 4'b0001);
      checkOutput("init_busy", 4'(busy), 4'd1);
      @(negedge clk);
      checkOutput("idle_reg_s", 4'(reg_s), 4'b0000);
      checkOutput("idle_busy", 4'(busy), 4'd0);
      checkOutput("idle_reg_q", reg_q, 4'b0000);

      // Single load of 1010 from requester 0.
      applyStimulus(1'b1, 2'b11, 4'b1010, 1'b0, 2'b00, 4'h0);
      #1;
      checkOutput("load_gnt", {2'b00, gnt1, gnt0}, 4'b0001);
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
      #1;
      checkOutput("load_issue_s", 4'(reg_s), 4'b0011);
      checkOutput("load_issue_d", reg_d, 4'b1010);
      checkOutput("load_issue_busy", 4'(busy), 4'd1);
      checkOutput("load_issue_gnt", {2'b00, gnt1, gnt0}, 4'b0000);
      @(negedge clk);
      checkOutput("load_cap_s", 4'(reg_s), 4'b0000);
      checkOutput("load_cap_q", reg_q, 4'b1010);
      checkOutput("load_cap_done", 4'(done), 4'd0);
      @(negedge clk);
      checkOutput("load_done", 4'(done), 4'd1);
      checkOutput("load_done_id", 4'(done_id), 4'd0);
      checkOutput("load_result", result, 4'b1010);
      checkOutput("load_busy", 4'(busy), 4'd0);

      // Negate from requester 1, granted in the same cycle as the previous done.
      applyStimulus(1'b0, 2'b00, 4'h0, 1'b1, 2'b10, 4'h0);
      #1;
      checkOutput("neg_gnt", {2'b00, gnt1, gnt0}, 4'b0010);
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b11, 4'b1111);
      #1;
      checkOutput("neg_issue_s", 4'(reg_s), 4'b0010);
      checkOutput("neg_issue_d", reg_d, 4'b0000);
      @(negedge clk);
      checkOutput("neg_cap_done", 4'(done), 4'd0);
      @(negedge clk);
      checkOutput("neg_done", 4'(done), 4'd1);
      checkOutput("neg_done_id", 4'(done_id), 4'd1);
      checkOutput("neg_result", result, 4'b0101);

      // Clear from requester 1 again: lone requester wins although the pointer favours 0.
      applyStimulus(1'b0, 2'b00, 4'h0, 1'b1, 2'b01, 4'b1111);
      #1;
      checkOutput("clr_gnt", {2'b00, gnt1, gnt0}, 4'b0010);
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
      #1;
      checkOutput("clr_issue_s", 4'(reg_s), 4'b0001);
      checkOutput("clr_issue_d", reg_d, 4'b0000);
      repeat (2) @(negedge clk);
      checkOutput("clr_done", 4'(done), 4'd1);
      checkOutput("clr_done_id", 4'(done_id), 4'd1);
      checkOutput("clr_result", result, 4'b0000);

      // Load 0110, then a hold operation that must report the unchanged value.
      applyStimulus(1'b1, 2'b11, 4'b0110, 1'b0, 2'b00, 4'h0);
      #1;
      checkOutput("ld6_gnt", {2'b00, gnt1, gnt0}, 4'b0001);
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
      repeat (2) @(negedge clk);
      checkOutput("ld6_result", result, 4'b0110);
      applyStimulus(1'b1, 2'b00, 4'b1001, 1'b0, 2'b00, 4'h0);
      #1;
      checkOutput("hold_gnt", {2'b00, gnt1, gnt0}, 4'b0001);
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
      #1;
      checkOutput("hold_issue_s", 4'(reg_s), 4'b0000);
      checkOutput("hold_issue_d", reg_d, 4'b0000);
      checkOutput("hold_issue_busy", 4'(busy), 4'd1);
      repeat (2) @(negedge clk);
      checkOutput("hold_done", 4'(done), 4'd1);
      checkOutput("hold_done_id", 4'(done_id), 4'd0);
      checkOutput("hold_result", result, 4'b0110);
      @(negedge clk);
      checkOutput("hold_done_pulse", 4'(done), 4'd0);
      checkOutput("hold_result_kept", result, 4'b0110);

      // Load 1111 from requester 0 (pointer then favours 1), aborted by reset during ISSUE.
      applyStimulus(1'b1, 2'b11, 4'b1111, 1'b0, 2'b00, 4'h0);
      #1;
      checkOutput("abort_gnt", {2'b00, gnt1, gnt0}, 4'b0001);
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
      #1;
      checkOutput("abort_issue_s", 4'(reg_s), 4'b0011);
      checkOutput("abort_issue_d", reg_d, 4'b1111);
      #1 rst = 1'b1;
      #1;
      checkOutput("abort_rst_s", 4'(reg_s), 4'b0001);
      checkOutput("abort_rst_d", reg_d, 4'b0000);
      checkOutput("abort_rst_busy", 4'(busy), 4'd1);
      checkOutput("abort_rst_result", result, 4'b0000);
      checkOutput("abort_rst_done", 4'(done), 4'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_init_s", 4'(reg_s), 4'b0001);
      checkOutput("abort_init_done", 4'(done), 4'd0);
      @(negedge clk);
      checkOutput("abort_idle_done", 4'(done), 4'd0);
      checkOutput("abort_idle_q", reg_q, 4'b0000);
      checkOutput("abort_idle_busy", 4'(busy), 4'd0);

      // Contention: both held with loads 0011 / 1100; grants alternate starting at 0.
      applyStimulus(1'b1, 2'b11, 4'b0011, 1'b1, 2'b11, 4'b1100);
      #1;
      checkOutput("cont_gnt0", {2'b00, gnt1, gnt0}, 4'b0001);
      for (int i = 1; i <= 4; i++) begin
         repeat (3) @(negedge clk);
         if (i == 4) applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
         #1;
         checkOutput("cont_done", 4'(done), 4'd1);
         checkOutput("cont_result", result, (i % 2 == 1) ? 4'b0011 : 4'b1100);
         checkOutput("cont_done_id", 4'(done_id), (i % 2 == 1) ? 4'd0 : 4'd1);
         checkOutput("cont_gnt", {2'b00, gnt1, gnt0},
                     (i == 4) ? 4'b0000 : ((i % 2 == 1) ? 4'b0010 : 4'b0001));
      end
      @(negedge clk);
      checkOutput("end_done", 4'(done), 4'd0);
      checkOutput("end_busy", 4'(busy), 4'd0);
      checkOutput("end_result", result, 4'b1100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
